// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: opcode constants,
// fetch FSM state encoding, default reset vector and immediate helpers.
package mips_pkg;

   // Primary opcode field values (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   // Default reset vector (word aligned)
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Fetch unit states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   // Sign-extended, word-scaled branch displacement
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   // Pseudo-direct jump target built from the upper PC nibble
   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [25:0] index);
      return {pc_plus4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next program counter selection: jump, taken branch, or sequential.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        branch,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] next_pc
);

   // Jump has priority over a taken branch; all sums wrap at 32 bits
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target(pc_plus4, instr[25:0]);
      end else if (branch && zero) begin
         next_pc = pc_plus4 + branch_offset(instr[15:0]);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over a req/ack handshake with a
// bounded wait, presents the instruction to the core and retires it
// on acceptance.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT  = 16
)
(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired,
   output logic        fetch_fault
);

   localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  retired_q, retired_d;
   logic [7:0]   wait_cnt_q, wait_cnt_d;
   logic         imem_req_q, imem_req_d;
   logic         instr_valid_q, instr_valid_d;
   logic         fetch_fault_q, fetch_fault_d;

   logic [31:0]  pc_plus4_w;
   logic [31:0]  next_pc_w;
   logic [7:0]   wait_inc;

   assign pc_plus4_w = pc_q + 32'd4;
   assign wait_inc   = wait_cnt_q + 8'd1;

   next_pc_calc u_next_pc (
      .pc_plus4 (pc_plus4_w),
      .instr    (instr_q),
      .branch   (branch),
      .jump     (jump),
      .zero     (zero),
      .next_pc  (next_pc_w)
   );

   // Next-state and registered-output logic for the fetch FSM
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      retired_d     = retired_q;
      wait_cnt_d    = wait_cnt_q;
      imem_req_d    = imem_req_q;
      instr_valid_d = instr_valid_q;
      fetch_fault_d = fetch_fault_q;
      case (state_q)
         IDLE: begin
            state_d    = FETCH;
            imem_req_d = 1'b1;
            wait_cnt_d = '0;
         end
         FETCH: begin
            // An ack in the last permitted wait cycle still wins over timeout
            if (imem_ack) begin
               state_d       = ISSUE;
               instr_d       = imem_rdata;
               imem_req_d    = 1'b0;
               instr_valid_d = 1'b1;
            end else if (wait_inc == TIMEOUT_W) begin
               state_d       = FAULT;
               imem_req_d    = 1'b0;
               fetch_fault_d = 1'b1;
               wait_cnt_d    = wait_inc;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               state_d       = FETCH;
               pc_d          = next_pc_w;
               retired_d     = retired_q + 32'd1;
               imem_req_d    = 1'b1;
               instr_valid_d = 1'b0;
               wait_cnt_d    = '0;
            end
         end
         FAULT: begin
            imem_req_d    = 1'b0;
            instr_valid_d = 1'b0;
            fetch_fault_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         retired_q     <= '0;
         wait_cnt_q    <= '0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         retired_q     <= retired_d;
         wait_cnt_q    <= wait_cnt_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         fetch_fault_q <= fetch_fault_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_w;
   assign retired     = retired_q;
   assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an address/instruction scoreboard.
// Instance 0: RESET_PC=0, TIMEOUT=4. Instance 1: RESET_PC=FFFF_FFFC.
// Instance 2: RESET_PC=3FFF_FFFC (reaches 0x4000_0000 for the jump case).
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n       [3];
   logic        imem_req    [3];
   logic [31:0] imem_addr   [3];
   logic        imem_ack    [3];
   logic [31:0] imem_rdata  [3];
   logic [31:0] instr       [3];
   logic [5:0]  op          [3];
   logic        instr_valid [3];
   logic        instr_ready [3];
   logic        branch      [3];
   logic        jump        [3];
   logic        zero        [3];
   logic [31:0] pc          [3];
   logic [31:0] pc_plus4    [3];
   logic [31:0] retired     [3];
   logic        fetch_fault [3];

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] exp_addr_q  [$];
   logic [31:0] exp_instr_q [$];
   logic [31:0] exp_ret     [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      instr_fetch_unit #(
         .RESET_PC (g == 0 ? 32'h0000_0000 : (g == 1 ? 32'hFFFF_FFFC : 32'h3FFF_FFFC)),
         .TIMEOUT  (g == 0 ? 4 : 16)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n[g]),
         .imem_req    (imem_req[g]),
         .imem_addr   (imem_addr[g]),
         .imem_ack    (imem_ack[g]),
         .imem_rdata  (imem_rdata[g]),
         .instr       (instr[g]),
         .op          (op[g]),
         .instr_valid (instr_valid[g]),
         .instr_ready (instr_ready[g]),
         .branch      (branch[g]),
         .jump        (jump[g]),
         .zero        (zero[g]),
         .pc          (pc[g]),
         .pc_plus4    (pc_plus4[g]),
         .retired     (retired[g]),
         .fetch_fault (fetch_fault[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int d, input logic [31:0] rpc);
      chk("rst_pc", pc[d], rpc);
      chk("rst_addr", imem_addr[d], rpc);
      chk("rst_instr", instr[d], 32'h0);
      chk("rst_op", {26'b0, op[d]}, 32'h0);
      chk1("rst_valid", instr_valid[d], 1'b0);
      chk1("rst_req", imem_req[d], 1'b0);
      chk("rst_retired", retired[d], 32'h0);
      chk1("rst_fault", fetch_fault[d], 1'b0);
   endtask

   // Wait (bounded) for a request, then check its address against the scoreboard
   task automatic wait_req(input int d);
      int n;
      n = 0;
      while (imem_req[d] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk1("req_rise", imem_req[d], 1'b1);
      if (exp_addr_q.size() > 0) chk("imem_addr", imem_addr[d], exp_addr_q.pop_front());
   endtask

   // Memory model: ack after 'delay' extra FETCH cycles, then check the issued word
   task automatic mem_ack(input int d, input int delay, input logic [31:0] word);
      logic [31:0] a0;
      logic [31:0] w;
      a0 = imem_addr[d];
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk1("req_hold", imem_req[d], 1'b1);
         chk("addr_hold", imem_addr[d], a0);
      end
      imem_ack[d]   = 1'b1;
      imem_rdata[d] = word;
      exp_instr_q.push_back(word);
      @(negedge clk);
      imem_ack[d]   = 1'b0;
      imem_rdata[d] = 32'hDEAD_BEEF;
      chk1("issue_valid", instr_valid[d], 1'b1);
      chk1("issue_req", imem_req[d], 1'b0);
      chk1("issue_fault", fetch_fault[d], 1'b0);
      w = exp_instr_q.pop_front();
      chk("instr", instr[d], w);
      chk("op", {26'b0, op[d]}, {26'b0, w[31:26]});
   endtask

   // Core accepts the held instruction with the given decoder/ALU outputs
   task automatic accept(input int d, input logic b, input logic j, input logic z,
                         input logic [31:0] exp_next);
      instr_ready[d] = 1'b1;
      branch[d]      = b;
      jump[d]        = j;
      zero[d]        = z;
      exp_addr_q.push_back(exp_next);
      exp_ret[d] = exp_ret[d] + 32'd1;
      @(negedge clk);
      instr_ready[d] = 1'b0;
      branch[d]      = 1'b0;
      jump[d]        = 1'b0;
      zero[d]        = 1'b0;
      chk("retired", retired[d], exp_ret[d]);
      chk1("valid_fall", instr_valid[d], 1'b0);
      wait_req(d);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i]       = 1'b0;
         imem_ack[i]    = 1'b0;
         imem_rdata[i]  = '0;
         instr_ready[i] = 1'b0;
         branch[i]      = 1'b0;
         jump[i]        = 1'b0;
         zero[i]        = 1'b0;
         exp_ret[i]     = '0;
      end
      @(negedge clk);
      @(negedge clk);
      chk_reset(0, 32'h0000_0000);
      chk_reset(1, 32'hFFFF_FFFC);
      chk_reset(2, 32'h3FFF_FFFC);

      // Sequential fetch with single-cycle ack and immediate acceptance
      rst_n[0] = 1'b1;
      exp_addr_q.push_back(32'h0000_0000);
      wait_req(0);
      mem_ack(0, 0, 32'h2008_0005);
      chk("pc_plus4", pc_plus4[0], 32'h0000_0004);
      accept(0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

      // Backpressure for five cycles in ISSUE
      mem_ack(0, 0, 32'h2008_0005);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_instr", instr[0], 32'h2008_0005);
         chk("bp_op", {26'b0, op[0]}, 32'd8);
         chk("bp_pc", pc[0], 32'h0000_0004);
         chk1("bp_valid", instr_valid[0], 1'b1);
         chk1("bp_req", imem_req[0], 1'b0);
         chk("bp_retired", retired[0], 32'd1);
      end
      accept(0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);

      // Ack in the last permitted wait cycle (TIMEOUT=4) succeeds
      mem_ack(0, 3, 32'h0000_0020);
      accept(0, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
      mem_ack(0, 1, 32'h2008_0005);
      accept(0, 1'b0, 1'b0, 1'b0, 32'h0000_0010);

      // Taken branch back by two words, then untaken
      mem_ack(0, 0, 32'h1000_FFFE);
      accept(0, 1'b1, 1'b0, 1'b1, 32'h0000_000C);
      mem_ack(0, 0, 32'h2008_0005);
      accept(0, 1'b0, 1'b0, 1'b0, 32'h0000_0010);
      mem_ack(0, 0, 32'h1000_FFFE);
      accept(0, 1'b1, 1'b0, 1'b0, 32'h0000_0014);

      // No ack: fault exactly TIMEOUT cycles after the request rose
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk1("to_wait_fault", fetch_fault[0], 1'b0);
         chk1("to_wait_req", imem_req[0], 1'b1);
      end
      @(negedge clk);
      chk1("to_fault", fetch_fault[0], 1'b1);
      chk1("to_req", imem_req[0], 1'b0);
      chk1("to_valid", instr_valid[0], 1'b0);
      chk("to_pc", pc[0], 32'h0000_0014);
      imem_ack[0]   = 1'b1;
      imem_rdata[0] = 32'h2008_0005;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         imem_ack[0] = 1'b0;
         chk1("fault_sticky", fetch_fault[0], 1'b1);
         chk1("fault_req", imem_req[0], 1'b0);
         chk1("fault_valid", instr_valid[0], 1'b0);
      end

      // Wrap: FFFF_FFFC + 4 fetches from 0
      rst_n[1] = 1'b1;
      exp_addr_q.push_back(32'hFFFF_FFFC);
      wait_req(1);
      mem_ack(1, 0, 32'h2008_0005);
      chk("wrap_pc_plus4", pc_plus4[1], 32'h0000_0000);
      accept(1, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

      // Jump wins over a taken branch; target keeps the upper PC nibble
      rst_n[2] = 1'b1;
      exp_addr_q.push_back(32'h3FFF_FFFC);
      wait_req(2);
      mem_ack(2, 0, 32'h2008_0005);
      accept(2, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
      mem_ack(2, 0, 32'h0800_0010);
      chk("jmp_pc", pc[2], 32'h4000_0000);
      accept(2, 1'b1, 1'b1, 1'b1, 32'h4000_0040);

      // Reset out of FAULT, then asynchronous reset in the middle of FETCH
      rst_n[0] = 1'b0;
      #1;
      chk_reset(0, 32'h0000_0000);
      @(negedge clk);
      rst_n[0] = 1'b1;
      exp_addr_q.push_back(32'h0000_0000);
      wait_req(0);
      #2;
      rst_n[0] = 1'b0;
      #1;
      chk_reset(0, 32'h0000_0000);
      @(negedge clk);
      chk_reset(0, 32'h0000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
